cond_jump_pipe: RTL and testbench

Two-stage pipelined condition and jump resolver for the CPU datapath.
- Sits directly downstream of the sign-test (less-than-zero) logic and the ALU result bus.
- Derives lt/eq/gt flags from the ALU result, matches them against the instruction's 3 jump bits, and produces the jump decision and the next PC.
- Uses a valid/ready handshake on both sides and keeps a saturating count of taken jumps.

---
 rtl/cond_jump_pipe.sv | 112 +++++++++++
 tb/tb_cond_jump_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_jump_pipe.sv
// Two-stage condition/jump resolver: stage A captures the ALU result and jump
// context, stage B holds the resolved jump decision, next PC and flags.
module cond_jump_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_result,
  input  logic [2:0]        in_jbits,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_jump,
  output logic [ADDR_W-1:0] out_next_pc,
  output logic [2:0]        out_flags,
  output logic [CNT_W-1:0]  taken_count
);

  logic              a_valid;
  logic [WIDTH-1:0]  a_result;
  logic [2:0]        a_jbits;
  logic [ADDR_W-1:0] a_pc;
  logic [ADDR_W-1:0] a_target;

  logic              b_valid;
  logic              b_jump;
  logic [ADDR_W-1:0] b_next_pc;
  logic [2:0]        b_flags;

  logic              lt, eq, gt;
  logic              jump_c;
  logic [ADDR_W-1:0] next_pc_c;
  logic              b_free;
  logic              accept;
  logic              out_fire;

  always_comb begin
    lt        = a_result[WIDTH-1];
    eq        = (a_result == '0);
    gt        = !lt && !eq;
    jump_c    = |(a_jbits & {lt, eq, gt});
    next_pc_c = jump_c ? a_target : a_pc + ADDR_W'(1);
  end

  // No skid buffer: in_ready sees out_ready combinationally through b_free.
  always_comb begin
    b_free   = !b_valid || out_ready;
    in_ready = !flush && (!a_valid || b_free);
    accept   = in_valid && in_ready;
    out_fire = b_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid  <= 1'b0;
      a_result <= '0;
      a_jbits  <= '0;
      a_pc     <= '0;
      a_target <= '0;
    end else begin
      if (flush)       a_valid <= 1'b0;
      else if (accept) a_valid <= 1'b1;
      else if (b_free) a_valid <= 1'b0;
      if (accept) begin
        a_result <= in_result;
        a_jbits  <= in_jbits;
        a_pc     <= in_pc;
        a_target <= in_target;
      end
    end
  end

  // B data only loads with a real beat so outputs stay put while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid   <= 1'b0;
      b_jump    <= 1'b0;
      b_next_pc <= '0;
      b_flags   <= '0;
    end else begin
      if (flush)       b_valid <= 1'b0;
      else if (b_free) b_valid <= a_valid;
      if (!flush && b_free && a_valid) begin
        b_jump    <= jump_c;
        b_next_pc <= next_pc_c;
        b_flags   <= {lt, eq, gt};
      end
    end
  end

  // A handshake completing in a flush cycle still counts.
  always_ff @(posedge clk) begin
    if (rst)
      taken_count <= '0;
    else if (out_fire && b_jump && (taken_count != '1))
      taken_count <= taken_count + CNT_W'(1);
  end

  always_comb begin
    out_valid   = b_valid;
    out_jump    = b_jump;
    out_next_pc = b_next_pc;
    out_flags   = b_flags;
  end

endmodule

// File: tb/tb_cond_jump_pipe.sv
// Directed bench for cond_jump_pipe: flags/jump decode, PC wrap, backpressure,
// flush, and counter saturation on a second instance with a 2-bit counter.
module tb_cond_jump_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_result, in_pc, in_target;
  logic [2:0]  in_jbits;

  logic        in_ready, out_valid, out_jump;
  logic [15:0] out_next_pc, taken_count;
  logic [2:0]  out_flags;

  logic        d2_in_ready, d2_out_valid, d2_out_jump;
  logic [15:0] d2_out_next_pc;
  logic [2:0]  d2_out_flags;
  logic [1:0]  d2_taken_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cond_jump_pipe #(.WIDTH(16), .ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_jbits(in_jbits), .in_pc(in_pc), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_jump(out_jump),
    .out_next_pc(out_next_pc), .out_flags(out_flags), .taken_count(taken_count)
  );

  cond_jump_pipe #(.WIDTH(16), .ADDR_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(d2_in_ready), .in_result(in_result),
    .in_jbits(in_jbits), .in_pc(in_pc), .in_target(in_target),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_jump(d2_out_jump),
    .out_next_pc(d2_out_next_pc), .out_flags(d2_out_flags), .taken_count(d2_taken_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_result = '0; in_jbits = '0; in_pc = '0; in_target = '0;
    step; step;
    rst = 1'b0;
    step;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++;
    if (taken_count !== 16'd0) begin n_fail++; $display("FAIL reset_taken_count got=%0d exp=0", taken_count); end
    n_tests++;
    if (out_next_pc !== 16'h0000 || out_jump !== 1'b0 || out_flags !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_out_data got pc=%h jump=%b flags=%b exp pc=0000 jump=0 flags=000",
               out_next_pc, out_jump, out_flags);
    end
  endtask

  task automatic test_flags;
    logic [15:0] v_res [6] = '{16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0005};
    logic [2:0]  v_jb  [6] = '{3'b100, 3'b100, 3'b001, 3'b011, 3'b111, 3'b000};
    logic [15:0] v_pc  [6] = '{16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'hFFFF};
    logic [2:0]  e_fl  [6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
    logic        e_j   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] e_pc  [6] = '{16'h0100, 16'h0011, 16'h0100, 16'h0011, 16'h0100, 16'h0000};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_result = v_res[i]; in_jbits = v_jb[i];
      in_pc = v_pc[i]; in_target = 16'h0100;
      step;
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flags_early_valid[%0d] got=%b exp=0", i, out_valid); end
      step;
      n_tests++;
      if (out_valid !== 1'b1 || out_jump !== e_j[i] || out_flags !== e_fl[i] || out_next_pc !== e_pc[i]) begin
        n_fail++;
        $display("FAIL flags_beat[%0d] got v=%b j=%b fl=%b pc=%h exp v=1 j=%b fl=%b pc=%h",
                 i, out_valid, out_jump, out_flags, out_next_pc, e_j[i], e_fl[i], e_pc[i]);
      end
    end
    step;
    n_tests++;
    if (taken_count !== 16'd3) begin n_fail++; $display("FAIL flags_taken_count got=%0d exp=3", taken_count); end
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int got  = 0;
    logic acc;
    out_ready = 1'b0;
    in_result = 16'h0001; in_jbits = 3'b000; in_target = 16'h0100;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_pc = 16'h0200 + 16'(sent);
      #1;
      acc = in_ready;
      step;
      if (acc) sent++;
      if (c >= 2) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_next_pc !== 16'h0201) begin
          n_fail++;
          $display("FAIL bp_hold[%0d] got v=%b pc=%h exp v=1 pc=0201", c, out_valid, out_next_pc);
        end
      end
    end
    n_tests++;
    if (sent != 2) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=2", sent); end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      in_valid = (sent < 5);
      in_pc = 16'h0200 + 16'(sent);
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        n_tests++;
        if (out_next_pc !== 16'h0201 + 16'(got)) begin
          n_fail++;
          $display("FAIL bp_order[%0d] got=%h exp=%h", got, out_next_pc, 16'h0201 + 16'(got));
        end
        got++;
      end
      step;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 5) begin n_fail++; $display("FAIL bp_delivered got=%0d exp=5", got); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_result = 16'h0000; in_jbits = 3'b111; in_target = 16'h0300;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_pc = 16'h0400 + 16'(c);
      step;
    end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    step;
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    n_tests++;
    if (taken_count !== 16'd4) begin n_fail++; $display("FAIL flush_taken_count got=%0d exp=4", taken_count); end
    step;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stage_a_cleared got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation;
    int exp_seq [5] = '{1, 2, 3, 3, 3};
    int sent = 0;
    int n = 0;
    logic hs, acc;
    rst = 1'b1; step; rst = 1'b0;
    n_tests++;
    if (d2_taken_count !== 2'd0) begin n_fail++; $display("FAIL sat_reset got=%0d exp=0", d2_taken_count); end
    out_ready = 1'b1; in_result = 16'h0000; in_jbits = 3'b111; in_target = 16'h0500;
    for (int c = 0; c < 20 && n < 5; c++) begin
      in_valid = (sent < 5);
      in_pc = 16'h0600 + 16'(sent);
      #1;
      acc = in_valid && d2_in_ready;
      hs  = d2_out_valid && out_ready && d2_out_jump;
      step;
      if (acc) sent++;
      if (hs) begin
        n_tests++;
        if (d2_taken_count !== 2'(exp_seq[n])) begin
          n_fail++;
          $display("FAIL sat_count[%0d] got=%0d exp=%0d", n, d2_taken_count, exp_seq[n]);
        end
        n++;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (n != 5) begin n_fail++; $display("FAIL sat_handshakes got=%0d exp=5", n); end
    in_valid = 1'b1; step; step;
    rst = 1'b1; step;
    rst = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (d2_taken_count !== 2'd0 || d2_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_midstream_rst got cnt=%0d v=%b exp cnt=0 v=0", d2_taken_count, d2_out_valid);
    end
    n_tests++;
    if (taken_count !== 16'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL main_midstream_rst got cnt=%0d v=%b exp cnt=0 v=0", taken_count, out_valid);
    end
  endtask

  initial begin
    test_reset;
    test_flags;
    test_backpressure;
    test_flush;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
